// File: rtl/approx_pkg.sv
// rtl/approx_pkg.sv - shared widths, FSM states and width helper for the approximate-adder error monitor.
package approx_pkg;

  localparam int OPW  = 6;  // adder operand width
  localparam int SUMW = 7;  // exact/approximate sum width
  localparam int DIFW = 8;  // signed per-sample difference width

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // Width that holds the values 0..win inclusive.
  function automatic int approx_cw(input int win);
    return $clog2(win + 1);
  endfunction

endpackage

// File: rtl/approx_err_dist.sv
// rtl/approx_err_dist.sv - per-sample exact sum, absolute error distance and signed difference.
module approx_err_dist
  import approx_pkg::*;
(
  input  logic        [OPW-1:0]  a,
  input  logic        [OPW-1:0]  b,
  input  logic        [SUMW-1:0] y,
  output logic        [SUMW-1:0] exact,
  output logic        [SUMW-1:0] ed,
  output logic signed [DIFW-1:0] sd
);

  logic [DIFW-1:0] neg_sd;

  // |sd| never exceeds 127, so the magnitude always fits in SUMW bits.
  always_comb begin
    exact  = SUMW'(a) + SUMW'(b);
    sd     = signed'({1'b0, y}) - signed'({1'b0, exact});
    neg_sd = -sd;
    ed     = sd[DIFW-1] ? neg_sd[SUMW-1:0] : sd[SUMW-1:0];
  end

endmodule

// File: rtl/approx_err_monitor.sv
// rtl/approx_err_monitor.sv - windowed error statistics (count, SED, max ED, bias) for an approximate adder.
module approx_err_monitor
  import approx_pkg::*;
#(
  parameter  int WIN = 64,
  parameter  int P   = 2,
  localparam int CW  = approx_cw(WIN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPW-1:0]       in_a,
  input  logic [OPW-1:0]       in_b,
  input  logic [SUMW-1:0]      in_y,
  output logic                 rep_valid,
  input  logic                 rep_ready,
  output logic [CW-1:0]        rep_err_cnt,
  output logic [SUMW+CW-1:0]   rep_sed,
  output logic [SUMW-1:0]      rep_max_ed,
  output logic [DIFW+CW-1:0]   rep_bias,
  output logic                 busy
);

  if (WIN < 1 || WIN > 1024 || P < 0 || P > OPW) begin : g_bad_param
    $error("approx_err_monitor: WIN must be 1..1024 and P 0..6");
  end

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       err_q;
  logic [SUMW+CW-1:0]  sed_q;
  logic [SUMW-1:0]     max_q;
  logic [DIFW+CW-1:0]  bias_q;

  logic [SUMW-1:0]        exact;
  logic [SUMW-1:0]        ed;
  logic signed [DIFW-1:0] sd;
  logic                   accept;
  logic                   last_sample;

  approx_err_dist u_dist (
    .a     (in_a),
    .b     (in_b),
    .y     (in_y),
    .exact (exact),
    .ed    (ed),
    .sd    (sd)
  );

  assign accept      = in_valid & in_ready;
  assign last_sample = (cnt_q == CW'(WIN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    rep_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last_sample) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        rep_valid = 1'b1;
        if (rep_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Accumulators clear on the start that opens a window and otherwise move only on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      err_q  <= '0;
      sed_q  <= '0;
      max_q  <= '0;
      bias_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      cnt_q  <= '0;
      err_q  <= '0;
      sed_q  <= '0;
      max_q  <= '0;
      bias_q <= '0;
    end else if (accept) begin
      cnt_q  <= cnt_q + CW'(1);
      if (in_y != exact) err_q <= err_q + CW'(1);
      sed_q  <= sed_q + {{CW{1'b0}}, ed};
      if (ed > max_q) max_q <= ed;
      bias_q <= bias_q + {{CW{sd[DIFW-1]}}, sd};
    end
  end

  assign rep_err_cnt = err_q;
  assign rep_sed     = sed_q;
  assign rep_max_ed  = max_q;
  assign rep_bias    = bias_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// tb/tb_approx_err_monitor.sv - scoreboard bench for approx_err_monitor (WIN=4 and WIN=1 instances).
module tb_approx_err_monitor;

  localparam int CW4 = 3;
  localparam int CW1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start, in_valid, rep_ready, in_ready, rep_valid, busy;
  logic [5:0]        in_a, in_b;
  logic [6:0]        in_y;
  logic [CW4-1:0]    rep_err_cnt;
  logic [6+CW4:0]    rep_sed;
  logic [6:0]        rep_max_ed;
  logic [7+CW4:0]    rep_bias;

  logic              start_1, in_valid_1, rep_ready_1, in_ready_1, rep_valid_1, busy_1;
  logic [5:0]        in_a_1, in_b_1;
  logic [6:0]        in_y_1;
  logic [CW1-1:0]    rep_err_cnt_1;
  logic [6+CW1:0]    rep_sed_1;
  logic [6:0]        rep_max_ed_1;
  logic [7+CW1:0]    rep_bias_1;

  approx_err_monitor #(.WIN(4), .P(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_y(in_y), .rep_valid(rep_valid), .rep_ready(rep_ready),
    .rep_err_cnt(rep_err_cnt), .rep_sed(rep_sed), .rep_max_ed(rep_max_ed),
    .rep_bias(rep_bias), .busy(busy)
  );

  approx_err_monitor #(.WIN(1), .P(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_1), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .in_a(in_a_1), .in_b(in_b_1), .in_y(in_y_1), .rep_valid(rep_valid_1), .rep_ready(rep_ready_1),
    .rep_err_cnt(rep_err_cnt_1), .rep_sed(rep_sed_1), .rep_max_ed(rep_max_ed_1),
    .rep_bias(rep_bias_1), .busy(busy_1)
  );

  typedef struct packed {
    logic [CW4-1:0] err;
    logic [6+CW4:0] sed;
    logic [6:0]     mx;
    logic [7+CW4:0] bias;
  } rep_t;

  rep_t sb[$];
  int checks = 0;
  int failures = 0;
  int m_err, m_sed, m_max, m_bias;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_window();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_err = 0; m_sed = 0; m_max = 0; m_bias = 0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL open_busy got=%b exp=1", busy);
    end
  endtask

  task automatic put(input logic [5:0] a, input logic [5:0] b, input logic [6:0] y);
    int g;
    int sd;
    int ad;
    in_a = a; in_b = b; in_y = y; in_valid = 1'b1;
    g = 0;
    while (in_ready !== 1'b1 && g < 50) begin
      tick();
      g++;
    end
    checks++;
    if (g >= 50) begin
      failures++;
      $display("FAIL put_timeout in_ready=%b exp=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    sd = int'(y) - (int'(a) + int'(b));
    ad = (sd < 0) ? -sd : sd;
    if (sd != 0) m_err++;
    m_sed += ad;
    if (ad > m_max) m_max = ad;
    m_bias += sd;
  endtask

  task automatic close_window();
    rep_t r;
    r.err  = CW4'(m_err);
    r.sed  = (7 + CW4)'(m_sed);
    r.mx   = 7'(m_max);
    r.bias = (8 + CW4)'(m_bias);
    sb.push_back(r);
  endtask

  task automatic collect(input string tag);
    int g;
    rep_t e;
    g = 0;
    while (rep_valid !== 1'b1 && g < 50) begin
      tick();
      g++;
    end
    checks++;
    if (g >= 50 || sb.size() == 0) begin
      failures++;
      $display("FAIL %s_report rep_valid=%b queued=%0d exp rep_valid=1 queued>0", tag, rep_valid, sb.size());
    end else begin
      e = sb.pop_front();
      checks += 5;
      if (rep_err_cnt !== e.err) begin failures++; $display("FAIL %s_err_cnt got=%0d exp=%0d", tag, rep_err_cnt, e.err); end
      if (rep_sed !== e.sed)     begin failures++; $display("FAIL %s_sed got=%0d exp=%0d", tag, rep_sed, e.sed); end
      if (rep_max_ed !== e.mx)   begin failures++; $display("FAIL %s_max_ed got=%0d exp=%0d", tag, rep_max_ed, e.mx); end
      if (rep_bias !== e.bias)   begin failures++; $display("FAIL %s_bias got=%0d exp=%0d", tag, $signed(rep_bias), $signed(e.bias)); end
      if (in_ready !== 1'b0)     begin failures++; $display("FAIL %s_ready_in_report got=%b exp=0", tag, in_ready); end
    end
    rep_ready = 1'b1;
    tick();
    rep_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || rep_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_back_to_idle busy=%b rep_valid=%b exp=0/0", tag, busy, rep_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({in_ready, rep_valid, busy, rep_err_cnt, rep_sed, rep_max_ed, rep_bias} !== '0 ||
        {in_ready_1, rep_valid_1, busy_1, rep_err_cnt_1, rep_sed_1, rep_max_ed_1, rep_bias_1} !== '0) begin
      failures++;
      $display("FAIL reset_outputs ready=%b valid=%b busy=%b sed=%0d exp all 0", in_ready, rep_valid, busy, rep_sed);
    end
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_accept ready=%b busy=%b exp=0/0", in_ready, busy);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mixed();
    open_window();
    put(6'd3, 6'd3, 7'd7);
    put(6'd1, 6'd1, 7'd1);
    put(6'd0, 6'd0, 7'd0);
    put(6'd63, 6'd63, 7'd127);
    close_window();
    checks++;
    if (rep_err_cnt !== 3'd3 || rep_sed !== 10'd3 || rep_max_ed !== 7'd1 || rep_bias !== 11'd1) begin
      failures++;
      $display("FAIL mixed_literal err=%0d sed=%0d max=%0d bias=%0d exp=3/3/1/1", rep_err_cnt, rep_sed, rep_max_ed, $signed(rep_bias));
    end
    collect("mixed");
  endtask

  task automatic test_exact();
    open_window();
    put(6'd10, 6'd20, 7'd30);
    put(6'd63, 6'd0, 7'd63);
    put(6'd5, 6'd7, 7'd12);
    checks++;
    if (rep_valid !== 1'b0) begin failures++; $display("FAIL exact_early_valid got=%b exp=0", rep_valid); end
    put(6'd63, 6'd63, 7'd126);
    checks++;
    if (rep_valid !== 1'b1) begin failures++; $display("FAIL exact_latency got=%b exp=1", rep_valid); end
    close_window();
    collect("exact");
  endtask

  task automatic test_stall();
    logic [29:0] snap;
    open_window();
    put(6'd3, 6'd3, 7'd7);   tick();
    put(6'd1, 6'd1, 7'd1);   tick();
    put(6'd0, 6'd0, 7'd0);   tick();
    put(6'd63, 6'd63, 7'd127);
    close_window();
    snap = {rep_err_cnt, rep_sed, rep_max_ed, rep_bias};
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (rep_valid !== 1'b1 || {rep_err_cnt, rep_sed, rep_max_ed, rep_bias} !== snap) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d valid=%b rep=%h exp valid=1 rep=%h", i, rep_valid, {rep_err_cnt, rep_sed, rep_max_ed, rep_bias}, snap);
      end
    end
    collect("stall");
  endtask

  task automatic test_mid_reset();
    open_window();
    put(6'd0, 6'd0, 7'd100);
    put(6'd9, 6'd9, 7'd0);
    checks++;
    if (rep_sed !== 10'd118) begin failures++; $display("FAIL midrst_live_sed got=%0d exp=118", rep_sed); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rep_valid, busy, in_ready, rep_err_cnt, rep_sed, rep_max_ed, rep_bias} !== '0) begin
      failures++;
      $display("FAIL midrst_clear valid=%b busy=%b sed=%0d bias=%0d exp all 0", rep_valid, busy, rep_sed, $signed(rep_bias));
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (rep_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL midrst_no_report valid=%b busy=%b exp=0/0", rep_valid, busy);
      end
    end
    open_window();
    put(6'd2, 6'd2, 7'd5);
    put(6'd2, 6'd2, 7'd4);
    put(6'd7, 6'd1, 7'd6);
    put(6'd0, 6'd1, 7'd1);
    close_window();
    collect("midrst_next");
  endtask

  task automatic test_start_ignored();
    logic [29:0] snap;
    open_window();
    put(6'd4, 6'd4, 7'd9);
    put(6'd1, 6'd2, 7'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || rep_sed !== 10'd4) begin
      failures++;
      $display("FAIL start_in_accum ready=%b sed=%0d exp=1/4", in_ready, rep_sed);
    end
    put(6'd30, 6'd30, 7'd64);
    put(6'd0, 6'd0, 7'd0);
    close_window();
    snap = {rep_err_cnt, rep_sed, rep_max_ed, rep_bias};
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (rep_valid !== 1'b1 || {rep_err_cnt, rep_sed, rep_max_ed, rep_bias} !== snap) begin
      failures++;
      $display("FAIL start_in_report valid=%b rep=%h exp valid=1 rep=%h", rep_valid, {rep_err_cnt, rep_sed, rep_max_ed, rep_bias}, snap);
    end
    collect("start_ign");
  endtask

  task automatic test_win1();
    start_1 = 1'b1;
    tick();
    start_1 = 1'b0;
    in_a_1 = 6'd0; in_b_1 = 6'd0; in_y_1 = 7'd127; in_valid_1 = 1'b1;
    checks++;
    if (in_ready_1 !== 1'b1) begin failures++; $display("FAIL win1_ready got=%b exp=1", in_ready_1); end
    tick();
    in_valid_1 = 1'b0;
    checks++;
    if (rep_valid_1 !== 1'b1 || rep_max_ed_1 !== 7'd127 || rep_sed_1 !== 8'd127 ||
        rep_bias_1 !== 9'd127 || rep_err_cnt_1 !== 1'b1) begin
      failures++;
      $display("FAIL win1_report valid=%b max=%0d sed=%0d bias=%0d err=%0d exp=1/127/127/127/1",
               rep_valid_1, rep_max_ed_1, rep_sed_1, $signed(rep_bias_1), rep_err_cnt_1);
    end
    rep_ready_1 = 1'b1;
    tick();
    rep_ready_1 = 1'b0;
    checks++;
    if (busy_1 !== 1'b0) begin failures++; $display("FAIL win1_idle busy=%b exp=0", busy_1); end
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 3; w++) begin
      open_window();
      for (int s = 0; s < 4; s++)
        put(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 7'($urandom_range(0, 127)));
      close_window();
      collect("b2b");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    start = 0; in_valid = 0; rep_ready = 0; in_a = 0; in_b = 0; in_y = 0;
    start_1 = 0; in_valid_1 = 0; rep_ready_1 = 0; in_a_1 = 0; in_b_1 = 0; in_y_1 = 0;
    test_reset();
    test_mixed();
    test_exact();
    test_stall();
    test_mid_reset();
    test_start_ignored();
    test_win1();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/approx_err_monitor.md
APPROX_ERR_MONITOR -- requirements
Module: approx_err_monitor

Interface
REQ-001 SHALL have parameter WIN, default 64, meaning samples per measurement window (legal range 1..1024).
REQ-002 SHALL have parameter P, default 2, meaning approximated LSBs of the monitored 6-bit adder; it is reported only and affects no arithmetic.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that opens a window.
REQ-006 SHALL have port in_valid, input, 1 bit: an upstream sample is present.
REQ-007 SHALL have port in_ready, output, 1 bit: the monitor accepts a sample this cycle.
REQ-008 SHALL have ports in_a and in_b, input, 6 bits each: the adder operands.
REQ-009 SHALL have port in_y, input, 7 bits: the approximate adder sum under test.
REQ-010 SHALL have port rep_valid, output, 1 bit: the report is held on the rep_* ports.
REQ-011 SHALL have port rep_ready, input, 1 bit: the consumer takes the report.
REQ-012 SHALL have port rep_err_cnt, output, CW=clog2(WIN+1) bits: count of samples with nonzero error.
REQ-013 SHALL have port rep_sed, output, 7+CW bits: sum of absolute error distances.
REQ-014 SHALL have port rep_max_ed, output, 7 bits: maximum absolute error distance.
REQ-015 SHALL have port rep_bias, output, 8+CW bits: signed sum of (in_y - exact), two's complement.
REQ-016 SHALL have port busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM and REPORT.
REQ-018 In IDLE, start=1 SHALL clear all accumulators and the sample counter and enter ACCUM on the next cycle.
REQ-019 A sample SHALL be accepted when in_valid and in_ready are both 1; in_ready SHALL be 1 only in ACCUM.
REQ-020 For each accepted sample, the monitor SHALL compute exact = in_a + in_b (7 bits, zero-extended), ed = |in_y - exact| (7 bits) and sd = in_y - exact (8-bit signed).
REQ-021 Each accepted sample SHALL update sample count, err_cnt (if ed != 0), sed += ed, max_ed = max(max_ed, ed) and bias += sd, all in the same clock edge.
REQ-022 No accumulator SHALL overflow; widths per REQ-012..015 are exact for WIN samples and no saturation is required.
REQ-023 When the accepted sample is the WIN-th, the FSM SHALL enter REPORT on that edge, so rep_valid is 1 in the following cycle (1-cycle latency).
REQ-024 In REPORT, rep_* values SHALL be stable while rep_valid=1 and SHALL leave REPORT only on rep_valid & rep_ready, returning to IDLE.
REQ-025 start SHALL be ignored in ACCUM and REPORT.
REQ-026 Cycles with in_valid=0 in ACCUM SHALL leave all state unchanged, with no timeout.
REQ-027 rep_* ports SHALL show the live accumulators in every state; only REPORT qualifies them.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state IDLE, in_ready=0, rep_valid=0, busy=0 and all counters and accumulators (hence all rep_* outputs) to 0.
REQ-029 Reset asserted mid-window SHALL discard the partial window; no report is produced.
REQ-030 After reset deassertion, no sample SHALL be accepted until a start pulse is seen.

Structure
REQ-031 FSM state enum, the width function CW and sample/error widths (6, 7, 8) SHALL live in shared package approx_pkg.
REQ-032 Combinational sub-module approx_err_dist SHALL compute exact, ed and sd from in_a, in_b and in_y; the FSM and accumulators SHALL stay in the top module.

Verification
REQ-033 WIN=4: start, then samples (a,b,y)=(3,3,7),(1,1,1),(0,0,0),(63,63,127) -> rep_err_cnt=3, rep_sed=3, rep_max_ed=1, rep_bias=+1.
REQ-034 WIN=4: four samples with y equal to the exact sum -> all rep_* fields 0 and rep_valid one cycle after the 4th accept.
REQ-035 in_valid toggling 1/0 with rep_ready held 0 for 10 cycles -> identical stats to REQ-033 and rep_* constant while rep_valid=1.
REQ-036 rst_n pulsed low after 2 of 4 samples -> rep_valid stays 0, outputs are 0, and the next window's stats exclude the pre-reset samples.
REQ-037 start pulsed during ACCUM and REPORT -> no effect; WIN=1 with (0,0,127) -> rep_max_ed=127, rep_sed=127, rep_bias=+127.
